// File: rtl/cpu_ctrl_pkg.sv
// ============================================================================
// Module      : cpu_ctrl_pkg
// Description : Shared types and constants for the multicycle control unit.
//               Contains the state encoding, opcode and funct values, ALU
//               operation codes and the datapath mux-select values.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_ctrl_pkg;

  // Debug-visible state encoding; values 20..63 are unused.
  typedef enum logic [5:0] {
    S_RESET     = 6'd0,
    S_FETCH     = 6'd1,
    S_DECODE    = 6'd2,
    S_EXEC_R    = 6'd3,
    S_WB_R      = 6'd4,
    S_ADDR_CALC = 6'd5,
    S_MEM_RD    = 6'd6,
    S_WB_LW     = 6'd7,
    S_MEM_WR    = 6'd8,
    S_BRANCH    = 6'd9,
    S_JUMP      = 6'd10,
    S_JAL       = 6'd11,
    S_JR        = 6'd12,
    S_EXEC_I    = 6'd13,
    S_WB_I      = 6'd14,
    S_LUI       = 6'd15,
    S_EXC_OPC   = 6'd16,
    S_EXC_OVF   = 6'd17,
    S_EXC_JUMP  = 6'd18,
    S_HALT      = 6'd19
  } state_t;

  // Primary opcodes (IR[31:26])
  localparam logic [5:0] c_op_rtype = 6'h00;
  localparam logic [5:0] c_op_j     = 6'h02;
  localparam logic [5:0] c_op_jal   = 6'h03;
  localparam logic [5:0] c_op_beq   = 6'h04;
  localparam logic [5:0] c_op_bne   = 6'h05;
  localparam logic [5:0] c_op_addi  = 6'h08;
  localparam logic [5:0] c_op_lui   = 6'h0F;
  localparam logic [5:0] c_op_lw    = 6'h23;
  localparam logic [5:0] c_op_sw    = 6'h2B;

  // R-type function codes (IR[5:0])
  localparam logic [5:0] c_fn_jr    = 6'h08;
  localparam logic [5:0] c_fn_break = 6'h0D;
  localparam logic [5:0] c_fn_add   = 6'h20;
  localparam logic [5:0] c_fn_sub   = 6'h22;
  localparam logic [5:0] c_fn_and   = 6'h24;
  localparam logic [5:0] c_fn_xor   = 6'h26;

  // ALU operation codes
  localparam logic [2:0] c_alu_load = 3'b000;
  localparam logic [2:0] c_alu_add  = 3'b001;
  localparam logic [2:0] c_alu_sub  = 3'b010;
  localparam logic [2:0] c_alu_and  = 3'b011;
  localparam logic [2:0] c_alu_xor  = 3'b110;

  // ALU B-operand select
  localparam logic [1:0] c_srcb_b       = 2'b00;
  localparam logic [1:0] c_srcb_four    = 2'b01;
  localparam logic [1:0] c_srcb_imm     = 2'b10;
  localparam logic [1:0] c_srcb_imm_sh2 = 2'b11;

  // Register-file destination select
  localparam logic [1:0] c_rdst_rt = 2'b00;
  localparam logic [1:0] c_rdst_rd = 2'b01;
  localparam logic [1:0] c_rdst_ra = 2'b10;

  // Register-file write-data select
  localparam logic [1:0] c_m2r_aluout = 2'b00;
  localparam logic [1:0] c_m2r_mdr    = 2'b01;
  localparam logic [1:0] c_m2r_pc     = 2'b10;
  localparam logic [1:0] c_m2r_lui    = 2'b11;

  // Next-PC select
  localparam logic [1:0] c_pcs_alu    = 2'b00;
  localparam logic [1:0] c_pcs_aluout = 2'b01;
  localparam logic [1:0] c_pcs_jump   = 2'b10;
  localparam logic [1:0] c_pcs_exc    = 2'b11;

  // ALU operation for the supported R-type arithmetic/logic functions.
  function automatic logic [2:0] alu_op_for_funct(input logic [5:0] funct);
    case (funct)
      c_fn_sub: return c_alu_sub;
      c_fn_and: return c_alu_and;
      c_fn_xor: return c_alu_xor;
      default:  return c_alu_add;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/mc_control_unit_mem_wait_timer.sv
// ============================================================================
// Module      : mem_wait_timer
// Description : 3-bit down-counter that paces memory-read states. Loaded on
//               entry to a wait state, counts down while enabled and flags
//               done when it has reached zero.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_wait_timer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_load,
  input  logic [2:0] i_load_val,
  input  logic       i_en,
  output logic       o_done
);

  logic [2:0] r_count;

  // Load takes priority; otherwise count down to zero and hold there.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= 3'd0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en && (r_count != 3'd0)) begin
      r_count <= r_count - 3'd1;
    end
  end

  assign o_done = (r_count == 3'd0);

endmodule

`default_nettype wire

// File: rtl/mc_control_unit.sv
// ============================================================================
// Module      : mc_control_unit
// Description : Multicycle MIPS-subset control FSM. Decodes Opcode/Funct and
//               drives every datapath strobe and mux select; the current
//               state is exported on Estado for debug.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mc_control_unit
  import cpu_ctrl_pkg::*;
#(
  parameter int MEM_LAT = 1
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [5:0] Opcode,
  input  logic [5:0] Funct,
  input  logic       Zero,
  input  logic       Overflow,
  output logic [5:0] Estado,
  output logic       DpReset,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       AWrite,
  output logic       BWrite,
  output logic       ALUOutWrite,
  output logic       MDRWrite,
  output logic       RegWrite,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IorD,
  output logic       EPCWrite,
  output logic       CauseWrite,
  output logic       IntCause,
  output logic       AluSrcA,
  output logic [1:0] AluSrcB,
  output logic [2:0] AluOp,
  output logic [1:0] RegDst,
  output logic [1:0] MemtoReg,
  output logic [1:0] PCSource
);

  localparam logic [2:0] c_mem_lat = 3'(MEM_LAT);

  state_t r_state;
  state_t w_state_next;
  logic   w_timer_load;
  logic   w_timer_en;
  logic   w_timer_done;

  // The counter is reloaded only on entry, so a wait state sees MEM_LAT+1 cycles.
  assign w_timer_load = ((w_state_next == S_FETCH)  && (r_state != S_FETCH)) ||
                        ((w_state_next == S_MEM_RD) && (r_state != S_MEM_RD));
  assign w_timer_en   = (r_state == S_FETCH) || (r_state == S_MEM_RD);

  mem_wait_timer u_wait (
    .clk        (Clock),
    .rst_n      (Reset),
    .i_load     (w_timer_load),
    .i_load_val (c_mem_lat),
    .i_en       (w_timer_en),
    .o_done     (w_timer_done)
  );

  // State register; reset aborts any instruction in flight.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_state <= S_RESET;
    end else begin
      r_state <= w_state_next;
    end
  end

  assign Estado = r_state;

  // Next-state decode and Moore outputs (PCWrite in BRANCH also follows Zero).
  always_comb begin
    w_state_next = S_RESET;
    DpReset      = 1'b0;
    PCWrite      = 1'b0;
    IRWrite      = 1'b0;
    AWrite       = 1'b0;
    BWrite       = 1'b0;
    ALUOutWrite  = 1'b0;
    MDRWrite     = 1'b0;
    RegWrite     = 1'b0;
    MemRead      = 1'b0;
    MemWrite     = 1'b0;
    IorD         = 1'b0;
    EPCWrite     = 1'b0;
    CauseWrite   = 1'b0;
    IntCause     = 1'b0;
    AluSrcA      = 1'b0;
    AluSrcB      = c_srcb_b;
    AluOp        = c_alu_load;
    RegDst       = c_rdst_rt;
    MemtoReg     = c_m2r_aluout;
    PCSource     = c_pcs_alu;

    case (r_state)
      S_RESET: begin
        DpReset      = 1'b1;
        w_state_next = S_FETCH;
      end
      S_FETCH: begin
        MemRead      = 1'b1;
        w_state_next = S_FETCH;
        if (w_timer_done) begin
          IRWrite      = 1'b1;
          PCWrite      = 1'b1;
          AluSrcB      = c_srcb_four;
          AluOp        = c_alu_add;
          PCSource     = c_pcs_alu;
          w_state_next = S_DECODE;
        end
      end
      S_DECODE: begin
        AWrite      = 1'b1;
        BWrite      = 1'b1;
        ALUOutWrite = 1'b1;
        AluSrcB     = c_srcb_imm_sh2;
        AluOp       = c_alu_add;
        case (Opcode)
          c_op_rtype: begin
            case (Funct)
              c_fn_add, c_fn_sub, c_fn_and, c_fn_xor: w_state_next = S_EXEC_R;
              c_fn_jr:                                w_state_next = S_JR;
              c_fn_break:                             w_state_next = S_HALT;
              default:                                w_state_next = S_EXC_OPC;
            endcase
          end
          c_op_lw, c_op_sw:   w_state_next = S_ADDR_CALC;
          c_op_beq, c_op_bne: w_state_next = S_BRANCH;
          c_op_j:             w_state_next = S_JUMP;
          c_op_jal:           w_state_next = S_JAL;
          c_op_addi:          w_state_next = S_EXEC_I;
          c_op_lui:           w_state_next = S_LUI;
          default:            w_state_next = S_EXC_OPC;
        endcase
      end
      S_EXEC_R: begin
        AluSrcA     = 1'b1;
        AluSrcB     = c_srcb_b;
        AluOp       = alu_op_for_funct(Funct);
        ALUOutWrite = 1'b1;
        if (Overflow && ((Funct == c_fn_add) || (Funct == c_fn_sub))) begin
          w_state_next = S_EXC_OVF;
        end else begin
          w_state_next = S_WB_R;
        end
      end
      S_WB_R: begin
        RegDst       = c_rdst_rd;
        RegWrite     = 1'b1;
        w_state_next = S_FETCH;
      end
      S_ADDR_CALC: begin
        AluSrcA      = 1'b1;
        AluSrcB      = c_srcb_imm;
        AluOp        = c_alu_add;
        ALUOutWrite  = 1'b1;
        w_state_next = (Opcode == c_op_lw) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        MemRead      = 1'b1;
        IorD         = 1'b1;
        w_state_next = S_MEM_RD;
        if (w_timer_done) begin
          MDRWrite     = 1'b1;
          w_state_next = S_WB_LW;
        end
      end
      S_WB_LW: begin
        RegDst       = c_rdst_rt;
        MemtoReg     = c_m2r_mdr;
        RegWrite     = 1'b1;
        w_state_next = S_FETCH;
      end
      S_MEM_WR: begin
        MemWrite     = 1'b1;
        IorD         = 1'b1;
        w_state_next = S_FETCH;
      end
      S_BRANCH: begin
        AluSrcA      = 1'b1;
        AluSrcB      = c_srcb_b;
        AluOp        = c_alu_sub;
        PCSource     = c_pcs_aluout;
        PCWrite      = (Opcode == c_op_bne) ? ~Zero : Zero;
        w_state_next = S_FETCH;
      end
      S_JUMP: begin
        PCSource     = c_pcs_jump;
        PCWrite      = 1'b1;
        w_state_next = S_FETCH;
      end
      S_JAL: begin
        // $31 captures the PC as it stands before this edge, i.e. PC+4.
        PCSource     = c_pcs_jump;
        PCWrite      = 1'b1;
        RegDst       = c_rdst_ra;
        MemtoReg     = c_m2r_pc;
        RegWrite     = 1'b1;
        w_state_next = S_FETCH;
      end
      S_JR: begin
        AluSrcA      = 1'b1;
        AluOp        = c_alu_load;
        PCSource     = c_pcs_alu;
        PCWrite      = 1'b1;
        w_state_next = S_FETCH;
      end
      S_EXEC_I: begin
        AluSrcA      = 1'b1;
        AluSrcB      = c_srcb_imm;
        AluOp        = c_alu_add;
        ALUOutWrite  = 1'b1;
        w_state_next = Overflow ? S_EXC_OVF : S_WB_I;
      end
      S_WB_I: begin
        RegDst       = c_rdst_rt;
        MemtoReg     = c_m2r_aluout;
        RegWrite     = 1'b1;
        w_state_next = S_FETCH;
      end
      S_LUI: begin
        RegDst       = c_rdst_rt;
        MemtoReg     = c_m2r_lui;
        RegWrite     = 1'b1;
        w_state_next = S_FETCH;
      end
      S_EXC_OPC, S_EXC_OVF: begin
        // EPC gets PC-4, the address of the faulting instruction.
        AluSrcA      = 1'b0;
        AluSrcB      = c_srcb_four;
        AluOp        = c_alu_sub;
        EPCWrite     = 1'b1;
        CauseWrite   = 1'b1;
        IntCause     = (r_state == S_EXC_OVF);
        w_state_next = S_EXC_JUMP;
      end
      S_EXC_JUMP: begin
        PCSource     = c_pcs_exc;
        PCWrite      = 1'b1;
        w_state_next = S_FETCH;
      end
      S_HALT: begin
        w_state_next = S_HALT;
      end
      default: begin
        w_state_next = S_RESET;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_mc_control_unit.sv
// ============================================================================
// Module      : tb_mc_control_unit
// Description : Self-checking bench for mc_control_unit. Two instances
//               (MEM_LAT=1 and MEM_LAT=2) are driven with directed
//               instructions; an instruction-level model predicts every
//               output cycle, plus hand-computed literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mc_control_unit;

  typedef struct packed {
    logic [5:0] estado;
    logic       dp_reset;
    logic       pc_write;
    logic       ir_write;
    logic       a_write;
    logic       b_write;
    logic       aluout_write;
    logic       mdr_write;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       epc_write;
    logic       cause_write;
    logic       int_cause;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] reg_dst;
    logic [1:0] memto_reg;
    logic [1:0] pc_source;
  } ctl_t;

  typedef struct {
    string       name;
    logic [63:0] a;
    logic [63:0] e;
  } lit_t;

  logic       clk = 1'b0;
  logic       rst_n [2];
  logic [5:0] opc   [2];
  logic [5:0] fn    [2];
  logic       zero  [2];
  logic       ovf   [2];
  ctl_t       act   [2];

  ctl_t q0 [$];
  ctl_t q1 [$];
  lit_t lit_q [$];
  ctl_t trace [$];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Two instances, MEM_LAT = k+1
  for (genvar k = 0; k < 2; k++) begin : g_dut
    logic [5:0] estado;
    logic       dp, pcw, irw, aw, bw, aow, mdrw, rw, mr, mw, iord, epcw, cw, ic, sa;
    logic [1:0] sb, rd, m2r, pcs;
    logic [2:0] aop;

    mc_control_unit #(.MEM_LAT(k + 1)) u_dut (
      .Clock(clk), .Reset(rst_n[k]), .Opcode(opc[k]), .Funct(fn[k]),
      .Zero(zero[k]), .Overflow(ovf[k]), .Estado(estado), .DpReset(dp),
      .PCWrite(pcw), .IRWrite(irw), .AWrite(aw), .BWrite(bw), .ALUOutWrite(aow),
      .MDRWrite(mdrw), .RegWrite(rw), .MemRead(mr), .MemWrite(mw), .IorD(iord),
      .EPCWrite(epcw), .CauseWrite(cw), .IntCause(ic), .AluSrcA(sa), .AluSrcB(sb),
      .AluOp(aop), .RegDst(rd), .MemtoReg(m2r), .PCSource(pcs)
    );

    assign act[k] = {estado, dp, pcw, irw, aw, bw, aow, mdrw, rw, mr, mw, iord,
                     epcw, cw, ic, sa, sb, aop, rd, m2r, pcs};
  end

  // Single compare process: model queues and literal expectations.
  always @(negedge clk) begin
    ctl_t e;
    lit_t l;
    if (q0.size() > 0) begin
      e = q0.pop_front();
      checks++;
      if (act[0] !== e) begin
        errors++;
        $display("FAIL cycle_dut0 t=%0t got %h want %h", $time, act[0], e);
      end
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      checks++;
      if (act[1] !== e) begin
        errors++;
        $display("FAIL cycle_dut1 t=%0t got %h want %h", $time, act[1], e);
      end
    end
    while (lit_q.size() > 0) begin
      l = lit_q.pop_front();
      checks++;
      if (l.a !== l.e) begin
        errors++;
        $display("FAIL %s got %0h want %0h", l.name, l.a, l.e);
      end
    end
  end

  // ---------------- model ----------------
  function automatic ctl_t st(input int s);
    ctl_t c = '0;
    c.estado = 6'(s);
    return c;
  endfunction

  task automatic push(input int k, input ctl_t c);
    if (k == 0) q0.push_back(c);
    else        q1.push_back(c);
  endtask

  function automatic int qsize(input int k);
    return (k == 0) ? q0.size() : q1.size();
  endfunction

  task automatic push_exc(input int k, input logic cause);
    ctl_t c;
    c = st(cause ? 17 : 16);
    c.alu_src_b = 2'b01; c.alu_op = 3'b010;
    c.epc_write = 1'b1; c.cause_write = 1'b1; c.int_cause = cause;
    push(k, c);
    c = st(18); c.pc_source = 2'b11; c.pc_write = 1'b1;
    push(k, c);
  endtask

  // Expected cycle list for one instruction, from FETCH to its last state.
  task automatic model_instr(input int k, input logic [5:0] op, input logic [5:0] f,
                             input logic z, input logic o);
    int   lat = k + 1;
    ctl_t c;
    logic rtype_alu;
    for (int i = 0; i <= lat; i++) begin
      c = st(1); c.mem_read = 1'b1;
      if (i == lat) begin
        c.ir_write = 1'b1; c.pc_write = 1'b1; c.alu_src_b = 2'b01; c.alu_op = 3'b001;
      end
      push(k, c);
    end
    c = st(2); c.a_write = 1'b1; c.b_write = 1'b1; c.aluout_write = 1'b1;
    c.alu_src_b = 2'b11; c.alu_op = 3'b001;
    push(k, c);
    rtype_alu = (op == 6'h00) && (f == 6'h20 || f == 6'h22 || f == 6'h24 || f == 6'h26);
    if (rtype_alu) begin
      c = st(3); c.alu_src_a = 1'b1; c.aluout_write = 1'b1;
      c.alu_op = (f == 6'h20) ? 3'b001 : (f == 6'h22) ? 3'b010 : (f == 6'h24) ? 3'b011 : 3'b110;
      push(k, c);
      if (o && (f == 6'h20 || f == 6'h22)) push_exc(k, 1'b1);
      else begin c = st(4); c.reg_dst = 2'b01; c.reg_write = 1'b1; push(k, c); end
    end else if (op == 6'h00 && f == 6'h08) begin
      c = st(12); c.alu_src_a = 1'b1; c.pc_write = 1'b1; push(k, c);
    end else if (op == 6'h00 && f == 6'h0D) begin
      for (int i = 0; i < 100; i++) push(k, st(19));
    end else if (op == 6'h23 || op == 6'h2B) begin
      c = st(5); c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; c.alu_op = 3'b001;
      c.aluout_write = 1'b1; push(k, c);
      if (op == 6'h23) begin
        for (int i = 0; i <= lat; i++) begin
          c = st(6); c.mem_read = 1'b1; c.iord = 1'b1; c.mdr_write = (i == lat);
          push(k, c);
        end
        c = st(7); c.memto_reg = 2'b01; c.reg_write = 1'b1; push(k, c);
      end else begin
        c = st(8); c.mem_write = 1'b1; c.iord = 1'b1; push(k, c);
      end
    end else if (op == 6'h04 || op == 6'h05) begin
      c = st(9); c.alu_src_a = 1'b1; c.alu_op = 3'b010; c.pc_source = 2'b01;
      c.pc_write = (op == 6'h04) ? z : !z; push(k, c);
    end else if (op == 6'h02) begin
      c = st(10); c.pc_source = 2'b10; c.pc_write = 1'b1; push(k, c);
    end else if (op == 6'h03) begin
      c = st(11); c.pc_source = 2'b10; c.pc_write = 1'b1; c.reg_dst = 2'b10;
      c.memto_reg = 2'b10; c.reg_write = 1'b1; push(k, c);
    end else if (op == 6'h08) begin
      c = st(13); c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; c.alu_op = 3'b001;
      c.aluout_write = 1'b1; push(k, c);
      if (o) push_exc(k, 1'b1);
      else begin c = st(14); c.reg_write = 1'b1; push(k, c); end
    end else if (op == 6'h0F) begin
      c = st(15); c.memto_reg = 2'b11; c.reg_write = 1'b1; push(k, c);
    end else begin
      push_exc(k, 1'b0);
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic lit(input string name, input logic [63:0] a, input logic [63:0] e);
    lit_t l;
    l.name = name; l.a = a; l.e = e;
    lit_q.push_back(l);
  endtask

  // Entered and left at posedge+1; on exit the DUT is in its first FETCH cycle.
  task automatic start(input int k);
    rst_n[k] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    lit($sformatf("reset_state_dut%0d", k), 64'(act[k]), 64'h0200_0000);
    rst_n[k] = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Runs one instruction; trace holds every cycle plus the following one.
  task automatic run(input int k, input logic [5:0] op, input logic [5:0] f,
                     input logic z, input logic o);
    int n = 0;
    opc[k] = op; fn[k] = f; zero[k] = z; ovf[k] = o;
    model_instr(k, op, f, z, o);
    trace.delete();
    trace.push_back(act[k]);
    while (qsize(k) > 0 && n < 200) begin
      @(posedge clk);
      #1;
      trace.push_back(act[k]);
      n++;
    end
    if (qsize(k) > 0) begin
      lit($sformatf("timeout_dut%0d_op%0h", k, op), 64'(qsize(k)), 64'd0);
      if (k == 0) q0.delete(); else q1.delete();
    end
  endtask

  function automatic int cnt_state(input int s);
    int n = 0;
    for (int i = 0; i < trace.size() - 1; i++) if (trace[i].estado == 6'(s)) n++;
    return n;
  endfunction

  function automatic ctl_t elem(input int s, input int off);
    for (int i = 0; i < trace.size(); i++)
      if (trace[i].estado == 6'(s) && i + off < trace.size()) return trace[i + off];
    return '1;
  endfunction

  function automatic int cnt_regw();
    int n = 0;
    for (int i = 0; i < trace.size() - 1; i++) if (trace[i].reg_write) n++;
    return n;
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    logic        regw_seen;
    logic [35:0] seq;
    ctl_t        c;
    for (int k = 0; k < 2; k++) begin
      rst_n[k] = 1'b0; opc[k] = 6'h00; fn[k] = 6'h20; zero[k] = 1'b0; ovf[k] = 1'b0;
    end

    // Reset in the middle of EXEC_R aborts the add
    start(0);
    opc[0] = 6'h00; fn[0] = 6'h20;
    regw_seen = act[0].reg_write;
    repeat (3) begin @(posedge clk); #1; regw_seen |= act[0].reg_write; end
    lit("in_exec_r", 64'(act[0].estado), 64'd3);
    #2 rst_n[0] = 1'b0;
    #1 lit("async_reset", 64'(act[0]), 64'h0200_0000);
    @(posedge clk); #1; regw_seen |= act[0].reg_write;
    rst_n[0] = 1'b1;
    @(posedge clk); #1;
    lit("fetch_after_reset", 64'(act[0].estado), 64'd1);
    lit("no_regwrite_abort", 64'(regw_seen), 64'd0);

    // add, MEM_LAT=1
    run(0, 6'h00, 6'h20, 1'b0, 1'b0);
    seq = '0;
    for (int i = 0; i < 6 && i < trace.size(); i++) seq = {seq[29:0], trace[i].estado};
    lit("add_seq", 64'(seq), 64'({6'd1, 6'd1, 6'd2, 6'd3, 6'd4, 6'd1}));
    lit("add_regw_count", 64'(cnt_regw()), 64'd1);
    lit("add_regdst", 64'(elem(4, 0).reg_dst), 64'd1);

    run(0, 6'h00, 6'h22, 1'b0, 1'b1);   // sub overflow
    lit("sub_ovf_regw", 64'(cnt_regw()), 64'd0);
    run(0, 6'h00, 6'h24, 1'b0, 1'b1);   // and ignores overflow
    run(0, 6'h00, 6'h26, 1'b0, 1'b0);   // xor
    run(0, 6'h04, 6'h00, 1'b1, 1'b0);   // beq taken
    c = elem(9, 0);
    lit("beq_z1_pcw", 64'(c.pc_write), 64'd1);
    lit("beq_z1_pcs", 64'(c.pc_source), 64'd1);
    run(0, 6'h04, 6'h00, 1'b0, 1'b0);
    lit("beq_z0_pcw", 64'(elem(9, 0).pc_write), 64'd0);
    run(0, 6'h05, 6'h00, 1'b1, 1'b0);
    lit("bne_z1_pcw", 64'(elem(9, 0).pc_write), 64'd0);
    run(0, 6'h05, 6'h00, 1'b0, 1'b0);
    lit("bne_z0_pcw", 64'(elem(9, 0).pc_write), 64'd1);
    run(0, 6'h02, 6'h00, 1'b0, 1'b0);   // j
    run(0, 6'h03, 6'h00, 1'b0, 1'b0);   // jal
    run(0, 6'h00, 6'h08, 1'b0, 1'b0);   // jr
    run(0, 6'h0F, 6'h00, 1'b0, 1'b0);   // lui
    run(0, 6'h3F, 6'h00, 1'b0, 1'b0);   // illegal opcode
    c = elem(16, 0);
    lit("opc_epc_cause", 64'({c.epc_write, c.cause_write, c.int_cause}), 64'h6);
    lit("opc_then_excjump", 64'({elem(16, 1).estado, elem(16, 1).pc_source}), 64'({6'd18, 2'b11}));
    lit("opc_then_fetch", 64'(elem(16, 2).estado), 64'd1);
    run(0, 6'h08, 6'h00, 1'b0, 1'b1);   // addi overflow
    lit("addi_ovf_cause", 64'({elem(17, 0).estado, elem(17, 0).int_cause}), 64'({6'd17, 1'b1}));
    lit("addi_ovf_regw", 64'(cnt_regw()), 64'd0);
    run(0, 6'h08, 6'h00, 1'b0, 1'b0);   // addi
    run(0, 6'h00, 6'h0D, 1'b0, 1'b0);   // break
    lit("halt_cycles", 64'(cnt_state(19) >= 100), 64'd1);
    lit("halt_stays", 64'(trace[trace.size() - 1].estado), 64'd19);

    // MEM_LAT=2 instance
    start(1);
    run(1, 6'h23, 6'h00, 1'b0, 1'b0);   // lw
    lit("lw_fetch_len", 64'(cnt_state(1)), 64'd3);
    lit("lw_memrd_len", 64'(cnt_state(6)), 64'd3);
    lit("lw_mdrw_first", 64'(elem(6, 0).mdr_write), 64'd0);
    lit("lw_mdrw_last", 64'(elem(7, -1).mdr_write), 64'd1);
    lit("lw_memtoreg", 64'(elem(7, 0).memto_reg), 64'd1);
    run(1, 6'h2B, 6'h00, 1'b0, 1'b0);   // sw
    lit("sw_memwr_len", 64'(cnt_state(8)), 64'd1);
    run(1, 6'h00, 6'h21, 1'b0, 1'b0);   // unsupported funct
    run(1, 6'h00, 6'h20, 1'b0, 1'b1);   // add overflow

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
